ov7670_frame_ctrl: RTL

Frame-level controller for the OV7670 capture path, in the `pclk` domain between the capture block's write port (`we`/`addr`) and a two-bank frame buffer. It aligns capture to whole frames and gates the write strobe. It validates each frame's line and pixel counts, and ping-pongs two banks so a consumer always reads a complete, stable frame through a hold/release handshake.

---
 rtl/ov7670_frame_ctrl_if.sv | 28 ++
 rtl/ov7670_frame_ctrl.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_ctrl_if.sv
// Signal bundle between the OV7670 frame controller and its camera, frame-buffer and consumer sides.
// The master drives camera/capture inputs and the consumer release; the slave is the controller.
interface ov7670_frame_ctrl_if;
  logic        enable;
  logic        vsync;
  logic        href;
  logic        cap_we;
  logic [16:0] cap_addr;
  logic        mem_we;
  logic [17:0] mem_addr;
  logic        frame_valid;
  logic        rd_bank;
  logic        rd_release;
  logic        frame_err;
  logic        busy;
  logic [7:0]  frame_cnt;
  logic [7:0]  drop_cnt;

  modport master (
    output enable, vsync, href, cap_we, cap_addr, rd_release,
    input  mem_we, mem_addr, frame_valid, rd_bank, frame_err, busy, frame_cnt, drop_cnt
  );

  modport slave (
    input  enable, vsync, href, cap_we, cap_addr, rd_release,
    output mem_we, mem_addr, frame_valid, rd_bank, frame_err, busy, frame_cnt, drop_cnt
  );
endinterface

// File: rtl/ov7670_frame_ctrl.sv
// Frame-aligned write gating, frame size validation and two-bank ping-pong handover
// for the OV7670 capture path; everything runs in the pixel clock domain.
module ov7670_frame_ctrl #(
  parameter int H_PIXELS = 320,
  parameter int V_LINES  = 240
) (
  input  logic               pclk,
  input  logic               rst_n,
  ov7670_frame_ctrl_if.slave bus
);

  localparam int          FRAME_WORDS = H_PIXELS * V_LINES;
  localparam logic [16:0] WORDS_MAX   = 17'(FRAME_WORDS);
  localparam logic [16:0] WORDS_SAT   = 17'(FRAME_WORDS + 1);
  localparam logic [8:0]  LINES_EXP   = 9'(V_LINES);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_e;

  state_e      state_q, state_d;
  logic        vs_q, hr_q;
  logic        vs_rise, vs_fall, hr_fall;
  logic [8:0]  line_q, line_d;
  logic [16:0] word_q, word_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic        fv_q, fv_d;
  logic        err_q, err_d;
  logic [7:0]  fcnt_q, fcnt_d;
  logic [7:0]  drop_q, drop_d;
  logic        eval, good, free;
  logic        busy, mem_we;

  function automatic logic [8:0] line_inc(input logic [8:0] v);
    return (v == 9'h1FF) ? v : v + 9'd1;
  endfunction

  // One count past a full frame is enough to flag an oversized frame.
  function automatic logic [16:0] word_inc(input logic [16:0] v);
    return (v >= WORDS_SAT) ? v : v + 17'd1;
  endfunction

  assign vs_rise = bus.vsync & ~vs_q;
  assign vs_fall = ~bus.vsync & vs_q;
  assign hr_fall = ~bus.href & hr_q;

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.enable) state_d = WAIT_VS;
      WAIT_VS: begin
        if (!bus.enable)  state_d = IDLE;
        else if (vs_fall) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (vs_rise)          state_d = bus.enable ? WAIT_VS : IDLE;
        else if (!bus.enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == CAPTURE);
    mem_we = bus.cap_we & busy & (word_q < WORDS_MAX);
  end

  // Counters are updated before evaluation so a word or line end on the vs_rise cycle still counts.
  always_comb begin
    line_d = line_q;
    word_d = word_q;
    if (state_q == WAIT_VS && bus.enable && vs_fall) begin
      line_d = '0;
      word_d = '0;
    end else if (state_q == CAPTURE) begin
      if (hr_fall)    line_d = line_inc(line_q);
      if (bus.cap_we) word_d = word_inc(word_q);
    end
  end

  assign eval = (state_q == CAPTURE) && vs_rise;
  assign good = (line_d == LINES_EXP) && (word_d == WORDS_MAX);
  assign free = ~fv_q | bus.rd_release;

  // Release is applied first, so a coincident release frees the held bank for this handover.
  always_comb begin
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    fv_d      = fv_q & ~bus.rd_release;
    err_d     = err_q;
    fcnt_d    = fcnt_q;
    drop_d    = drop_q;
    if (eval) begin
      if (good) begin
        err_d = 1'b0;
        if (free) begin
          rd_bank_d = wr_bank_q;
          wr_bank_d = ~wr_bank_q;
          fv_d      = 1'b1;
          fcnt_d    = fcnt_q + 8'd1;
        end else begin
          drop_d = drop_q + 8'd1;
        end
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q      <= 1'b0;
      hr_q      <= 1'b0;
      line_q    <= '0;
      word_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      fv_q      <= 1'b0;
      err_q     <= 1'b0;
      fcnt_q    <= '0;
      drop_q    <= '0;
    end else begin
      vs_q      <= bus.vsync;
      hr_q      <= bus.href;
      line_q    <= line_d;
      word_q    <= word_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      fv_q      <= fv_d;
      err_q     <= err_d;
      fcnt_q    <= fcnt_d;
      drop_q    <= drop_d;
    end
  end

  assign bus.mem_we      = mem_we;
  assign bus.mem_addr    = {wr_bank_q, bus.cap_addr};
  assign bus.frame_valid = fv_q;
  assign bus.rd_bank     = rd_bank_q;
  assign bus.frame_err   = err_q;
  assign bus.busy        = busy;
  assign bus.frame_cnt   = fcnt_q;
  assign bus.drop_cnt    = drop_q;

endmodule
